// File: rtl/addr_led_latch_pkg.sv
// -----------------------------------------------------------------------------
// addr_led_latch_pkg
//   Shared definitions for the addressed LED latch: the write-button FSM
//   state encoding and the default debounce length.
// -----------------------------------------------------------------------------
package addr_led_latch_pkg;

   // Write-button debounce FSM.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // button released, waiting for a press
      PRESS = 2'd1,   // press seen, debouncing before commit
      HELD  = 2'd2,   // write committed, waiting for release
      REL   = 2'd3    // release seen, debouncing before re-arming
   } state_t;

   // 1 ms at 50 MHz.
   localparam int DB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/addr_led_latch_if.sv
// -----------------------------------------------------------------------------
// addr_led_latch_if
//   Board-side signal bundle of the addressed LED latch.
//   master : drives the switch/buttons, observes the LEDs (board/testbench)
//   slave  : the latch itself
//   din    : data switch
//   sel_n  : address buttons, active-low
//   wr_n   : write button, active-low, bouncy
//   q      : latched LED bits
//   wr_ack : one-cycle pulse after each commit
//   busy   : FSM not in IDLE
// -----------------------------------------------------------------------------
interface addr_led_latch_if #(
   parameter int SEL_W = 2,
   parameter int N_OUT = 4
);
   logic             din;
   logic [SEL_W-1:0] sel_n;
   logic             wr_n;
   logic [N_OUT-1:0] q;
   logic             wr_ack;
   logic             busy;

   modport master (output din, sel_n, wr_n, input  q, wr_ack, busy);
   modport slave  (input  din, sel_n, wr_n, output q, wr_ack, busy);
endinterface

// File: rtl/addr_led_latch_btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
//   Two-flop synchronizer for asynchronous board inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input (W bits)
//   q     : synchronized output (W bits), two clk edges behind d
// -----------------------------------------------------------------------------
module btn_sync #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // NOTE: non-blocking assignments so both stages sample on the same edge;
   // blocking here would collapse the chain into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/addr_led_latch.sv
// -----------------------------------------------------------------------------
// addr_led_latch
//   Writes one data switch into one of N_OUT LED bits, addressed by active-low
//   buttons, when an active-low write button is pressed and debounced.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (discards any pending write)
//   bus   : addr_led_latch_if.slave (din, sel_n, wr_n in; q, wr_ack, busy out)
// -----------------------------------------------------------------------------
module addr_led_latch
   import addr_led_latch_pkg::*;
#(
   parameter int N_OUT     = 4,
   parameter int SEL_W     = 2,
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   addr_led_latch_if.slave   bus
);

   localparam int             CNT_W    = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             din_s;
   logic [SEL_W-1:0] sel_n_s;
   logic             wr_s;

   btn_sync #(.W(1), .RST_VAL(1'b0)) u_din_sync (
      .clk, .rst_n, .d(bus.din), .q(din_s)
   );

   btn_sync #(.W(SEL_W), .RST_VAL({SEL_W{1'b1}})) u_sel_sync (
      .clk, .rst_n, .d(bus.sel_n), .q(sel_n_s)
   );

   // Reset value 1 = button released, so reset never looks like a press.
   btn_sync #(.W(1), .RST_VAL(1'b1)) u_wr_sync (
      .clk, .rst_n, .d(bus.wr_n), .q(wr_s)
   );

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [N_OUT-1:0] q_r, q_nx;
   logic             commit;
   logic             wr_ack_r, busy_r;
   logic [SEL_W-1:0] sel;

   assign sel = ~sel_n_s;

   // NOTE: every output of this block gets a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      q_nx     = q_r;
      commit   = 1'b0;

      unique case (state)
         IDLE: begin
            if (!wr_s) begin
               state_nx = PRESS;
               cnt_nx   = '0;
            end
         end
         PRESS: begin
            // A single high sample during the press is treated as bounce.
            if (wr_s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = HELD;
               cnt_nx   = '0;
               commit   = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (wr_s) begin
               state_nx = REL;
               cnt_nx   = '0;
            end
         end
         REL: begin
            if (!wr_s) begin
               state_nx = HELD;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      // Addresses at or beyond N_OUT match no bit; the ack still pulses.
      for (int i = 0; i < N_OUT; i++) begin
         if (commit && (sel == SEL_W'(i))) q_nx[i] = din_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         q_r      <= '0;
         wr_ack_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         q_r      <= q_nx;
         wr_ack_r <= commit;
         busy_r   <= (state_nx != IDLE);
      end
   end

   assign bus.q      = q_r;
   assign bus.wr_ack = wr_ack_r;
   assign bus.busy   = busy_r;

endmodule
